dot_operand_fetch: RTL

- Upstream feeder for the dot-product pipeline.
- On `start`, walks two synchronous-read operand memories (mem1, mem2) from programmable base addresses.
- Streams `num_vectors` × VECTOR_WIDTH element pairs as registered `data_from_mem1`/`data_from_mem2` with a `data_valid` strobe, ready to connect directly to the dot-product block's inputs.
- Supports a `pause` input that stalls issue without losing in-flight reads. Reports `busy` and a `done` pulse.

---
 rtl/dot_operand_fetch.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dot_operand_fetch.sv
// dot_operand_fetch
//   Operand feeder for the dot-product pipeline. On an accepted start it walks
//   two synchronous-read memories from latched base addresses and streams
//   num_vectors * VECTOR_WIDTH element pairs as registered data with a valid
//   strobe and an end-of-vector marker.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle request, only looked at in IDLE
//   base_addr1/2, num_vectors  run parameters, latched on an accepted start
//   pause                      suppresses issue in the current cycle (FETCH only)
//   mem1/2_rd_en, mem1/2_addr  combinational read request to the memories
//   mem1/2_rdata               memory data, one cycle after the read request
//   data_from_mem1/2           registered element pair
//   data_valid, elem_last      pair is valid / pair is the last of its vector
//   busy, done                 run in progress / one-cycle completion pulse
//   state_dbg                  current FSM state (IDLE=0 FETCH=1 DRAIN=2 DONE=3)
//
// Handshake: there is no backpressure. data_valid is a one-cycle qualifier and
// the consumer must take every pair in the cycle it is presented; elem_last is
// meaningful only while data_valid is high and is forced low otherwise.

module dot_operand_fetch #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUMV_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr1,
  input  logic [ADDR_WIDTH-1:0] base_addr2,
  input  logic [NUMV_WIDTH-1:0] num_vectors,
  input  logic                  pause,
  output logic                  mem1_rd_en,
  output logic [ADDR_WIDTH-1:0] mem1_addr,
  input  logic [DATA_WIDTH-1:0] mem1_rdata,
  output logic                  mem2_rd_en,
  output logic [ADDR_WIDTH-1:0] mem2_addr,
  input  logic [DATA_WIDTH-1:0] mem2_rdata,
  output logic [DATA_WIDTH-1:0] data_from_mem1,
  output logic [DATA_WIDTH-1:0] data_from_mem2,
  output logic                  data_valid,
  output logic                  elem_last,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  localparam int ELEM_W = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam logic [ELEM_W-1:0] ELEM_MAX = ELEM_W'(VECTOR_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr1_q, ptr1_d;
  logic [ADDR_WIDTH-1:0] ptr2_q, ptr2_d;
  logic [NUMV_WIDTH-1:0] numv_q, numv_d;
  logic [ELEM_W-1:0]     elem_cnt_q, elem_cnt_d;
  logic [NUMV_WIDTH-1:0] vec_cnt_q, vec_cnt_d;
  // Delay stage that travels alongside the memory's one-cycle read latency.
  logic                  dly_valid_q, dly_valid_d;
  logic                  dly_last_q, dly_last_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic [DATA_WIDTH-1:0] data2_q, data2_d;
  logic                  data_valid_q, data_valid_d;
  logic                  elem_last_q, elem_last_d;
  logic                  issue;

  always_comb begin
    state_d      = state_q;
    ptr1_d       = ptr1_q;
    ptr2_d       = ptr2_q;
    numv_d       = numv_q;
    elem_cnt_d   = elem_cnt_q;
    vec_cnt_d    = vec_cnt_q;
    issue        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr1_d     = base_addr1;
          ptr2_d     = base_addr2;
          numv_d     = num_vectors;
          elem_cnt_d = '0;
          vec_cnt_d  = '0;
          state_d    = (num_vectors == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!pause) begin
          issue  = 1'b1;
          // Pointers wrap naturally at the address width.
          ptr1_d = ptr1_q + ADDR_WIDTH'(1);
          ptr2_d = ptr2_q + ADDR_WIDTH'(1);
          if (elem_cnt_q == ELEM_MAX) begin
            elem_cnt_d = '0;
            if (vec_cnt_q == numv_q - NUMV_WIDTH'(1)) begin
              state_d = S_DRAIN;
            end else begin
              vec_cnt_d = vec_cnt_q + NUMV_WIDTH'(1);
            end
          end else begin
            elem_cnt_d = elem_cnt_q + ELEM_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Once the delay stage is empty the final pair is already sitting in
        // the output register, so done lands the cycle after that last pair.
        if (!dly_valid_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    dly_valid_d  = issue;
    dly_last_d   = issue && (elem_cnt_q == ELEM_MAX);
    data_valid_d = dly_valid_q;
    elem_last_d  = dly_last_q;
    // Output data holds its previous value whenever no read returns.
    data1_d      = dly_valid_q ? mem1_rdata : data1_q;
    data2_d      = dly_valid_q ? mem2_rdata : data2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr1_q       <= '0;
      ptr2_q       <= '0;
      numv_q       <= '0;
      elem_cnt_q   <= '0;
      vec_cnt_q    <= '0;
      dly_valid_q  <= 1'b0;
      dly_last_q   <= 1'b0;
      data1_q      <= '0;
      data2_q      <= '0;
      data_valid_q <= 1'b0;
      elem_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr1_q       <= ptr1_d;
      ptr2_q       <= ptr2_d;
      numv_q       <= numv_d;
      elem_cnt_q   <= elem_cnt_d;
      vec_cnt_q    <= vec_cnt_d;
      dly_valid_q  <= dly_valid_d;
      dly_last_q   <= dly_last_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      data_valid_q <= data_valid_d;
      elem_last_q  <= elem_last_d;
    end
  end

  assign mem1_rd_en     = issue;
  assign mem2_rd_en     = issue;
  assign mem1_addr      = ptr1_q;
  assign mem2_addr      = ptr2_q;
  assign data_from_mem1 = data1_q;
  assign data_from_mem2 = data2_q;
  assign data_valid     = data_valid_q;
  assign elem_last      = elem_last_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign state_dbg      = state_q;

endmodule
